// File: rtl/hpi_pkg.sv
// Shared types for the CY7C67200 HPI bus sequencer: HPI register select,
// command kinds and sequencer states.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_e;

    typedef enum logic [1:0] {
        MEM_WR = 2'd0,
        MEM_RD = 2'd1,
        MBX_WR = 2'd2,
        STS_RD = 2'd3
    } hpi_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_STB,
        S_ADDR_GAP,
        S_DATA_WAIT,
        S_DATA_STB,
        S_DATA_GAP
    } seq_state_e;

    function automatic hpi_reg_e data_reg(hpi_cmd_e k);
        case (k)
            MBX_WR:  return HPI_MAILBOX;
            STS_RD:  return HPI_STATUS;
            default: return HPI_DATA;
        endcase
    endfunction

    function automatic logic is_read(hpi_cmd_e k);
        return (k == MEM_RD) || (k == STS_RD);
    endfunction

endpackage

// File: rtl/hpi_sequencer.sv
// Sequences HPI bus cycles (ADDRESS/DATA/MAILBOX/STATUS) on the hpi_io_intf
// from_sw_* strobes with programmable strobe and recovery lengths.
module hpi_sequencer
    import hpi_pkg::*;
#(
    parameter int unsigned STB_CYC = 3,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_kind,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        done,
    output logic [1:0]  from_sw_address,
    output logic [15:0] from_sw_data_out,
    output logic        from_sw_r,
    output logic        from_sw_w,
    output logic        from_sw_cs,
    input  logic [15:0] from_sw_data_in
);

    localparam logic [3:0] STB_LAST = 4'(STB_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);
    localparam logic [3:0] GAP_DONE = 4'(GAP_CYC - 2);
    // Second gap cycle: read data has crossed the interface's output and input registers.
    localparam logic [3:0] GAP_CAPT = 4'd1;

    seq_state_e  state_q, state_d;
    hpi_cmd_e    kind_q, kind_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [3:0]  phase_q, phase_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_ready_q, wr_ready_d;
    logic        rd_valid_q, rd_valid_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic [1:0]  address_q, address_d;
    logic [15:0] data_out_q, data_out_d;
    logic        r_q, r_d, w_q, w_d, cs_q, cs_d;

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_out_d  = data_out_q;
        address_d   = address_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        cs_d        = 1'b1;
        r_d         = 1'b1;
        w_d         = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    kind_d = hpi_cmd_e'(cmd_kind);
                    addr_d = cmd_addr;
                    case (kind_d)
                        MEM_WR, MEM_RD: begin
                            remaining_d = (cmd_len == 8'd0) ? 8'd1 : cmd_len;
                            state_d     = S_ADDR_STB;
                        end
                        MBX_WR: begin
                            remaining_d = 8'd1;
                            state_d     = S_DATA_WAIT;
                        end
                        default: begin
                            remaining_d = 8'd1;
                            state_d     = S_DATA_STB;
                        end
                    endcase
                end
            end
            S_ADDR_STB: if (phase_q == STB_LAST) state_d = S_ADDR_GAP;
            S_ADDR_GAP: begin
                if (phase_q == GAP_LAST)
                    state_d = (kind_q == MEM_RD) ? S_DATA_STB : S_DATA_WAIT;
            end
            S_DATA_WAIT: begin
                if (wr_valid) begin
                    data_out_d = wr_data;
                    state_d    = S_DATA_STB;
                end
            end
            S_DATA_STB: if (phase_q == STB_LAST) state_d = S_DATA_GAP;
            S_DATA_GAP: begin
                if (is_read(kind_q) && phase_q == GAP_CAPT) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = from_sw_data_in;
                end
                // Lands on the last gap cycle so cmd_ready follows one cycle later.
                if (phase_q == GAP_DONE && remaining_q == 8'd1)
                    done_d = 1'b1;
                if (phase_q == GAP_LAST) begin
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1)
                        state_d = S_IDLE;
                    else
                        state_d = is_read(kind_q) ? S_DATA_STB : S_DATA_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == state_q &&
            (state_q == S_ADDR_STB || state_q == S_ADDR_GAP ||
             state_q == S_DATA_STB || state_q == S_DATA_GAP))
            phase_d = phase_q + 4'd1;
        else
            phase_d = 4'd0;

        // Bus outputs are decoded from the next state so they register in step with it.
        case (state_d)
            S_ADDR_STB: begin
                address_d  = HPI_ADDRESS;
                data_out_d = addr_d;
                cs_d       = 1'b0;
                w_d        = 1'b0;
            end
            S_DATA_STB: begin
                address_d = data_reg(kind_d);
                cs_d      = 1'b0;
                if (is_read(kind_d)) r_d = 1'b0;
                else                 w_d = 1'b0;
            end
            default: ;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        wr_ready_d  = (state_d == S_DATA_WAIT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            kind_q      <= MEM_WR;
            addr_q      <= 16'd0;
            remaining_q <= 8'd0;
            phase_q     <= 4'd0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 16'd0;
            done_q      <= 1'b0;
            address_q   <= 2'd0;
            data_out_q  <= 16'd0;
            r_q         <= 1'b1;
            w_q         <= 1'b1;
            cs_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            r_q         <= r_d;
            w_q         <= w_d;
            cs_q        <= cs_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign wr_ready         = wr_ready_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign done             = done_q;
    assign from_sw_address  = address_q;
    assign from_sw_data_out = data_out_q;
    assign from_sw_r        = r_q;
    assign from_sw_w        = w_q;
    assign from_sw_cs       = cs_q;

endmodule
